// File: rtl/data_sram_if.sv
// Data-SRAM request/response bus between the EX/MEM stages (master)
// and the data-memory responder (slave).
interface data_sram_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata, err
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata, err
  );
endinterface

// File: rtl/data_sram_responder.sv
// Data-SRAM responder: word-addressed memory with lane-masked stores,
// one outstanding request and a fixed request-to-response latency.
module data_sram_responder #(
  parameter int ADDR_LOG2 = 10,
  parameter int LAT       = 1
) (
  input  logic        clk,
  input  logic        reset,
  data_sram_if.slave  bus
);

  localparam int         AW     = ADDR_LOG2 + 2;
  localparam int         DEPTH  = 1 << ADDR_LOG2;
  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  function automatic logic [3:0] f_byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'd0:    f_byte_en = 4'b0001 << lane;
      2'd1:    f_byte_en = lane[1] ? 4'b1100 : 4'b0011;
      2'd2:    f_byte_en = 4'b1111;
      default: f_byte_en = 4'b0000;
    endcase
  endfunction

  function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'd0:    f_misaligned = 1'b0;
      2'd1:    f_misaligned = lane[0];
      2'd2:    f_misaligned = (lane != 2'd0);
      default: f_misaligned = 1'b1;
    endcase
  endfunction

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_data_ok;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [AW-1:0]     r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_mem [0:DEPTH-1];

  state_t            w_nxt_state;
  logic [3:0]        w_nxt_cnt;
  logic              w_addr_ok;
  logic              w_accept;
  logic              w_resp_next;
  logic              w_commit;
  logic [3:0]        w_commit_be;
  logic              w_sel_wr;
  logic [1:0]        w_sel_size;
  logic [AW-1:0]     w_sel_addr;
  logic [31:0]       w_rd_word;
  logic [31:0]       w_resp_rdata;
  logic              w_resp_err;

  assign w_addr_ok   = (r_state == IDLE) | r_data_ok;
  assign w_accept    = bus.req & w_addr_ok;
  assign w_commit    = r_data_ok & r_wr & ~f_misaligned(r_size, r_addr[1:0]);
  assign w_commit_be = f_byte_en(r_size, r_addr[1:0]);

  // The request answered next cycle is the incoming one only when LAT = 1.
  assign w_sel_wr   = w_accept ? bus.wr   : r_wr;
  assign w_sel_size = w_accept ? bus.size : r_size;
  assign w_sel_addr = w_accept ? bus.addr[AW-1:0] : r_addr;

  always_comb begin
    w_nxt_state = IDLE;
    w_nxt_cnt   = 4'd0;
    if (w_accept) begin
      w_nxt_state = BUSY;
      w_nxt_cnt   = LAT_M1;
    end else if ((r_state == BUSY) && !r_data_ok) begin
      w_nxt_state = BUSY;
      w_nxt_cnt   = r_cnt - 4'd1;
    end else begin
      w_nxt_state = IDLE;
      w_nxt_cnt   = 4'd0;
    end
  end

  assign w_resp_next = (w_nxt_state == BUSY) && (w_nxt_cnt == 4'd0);

  // Forward a store committing on the same edge the read word is captured.
  always_comb begin
    w_rd_word = r_mem[w_sel_addr[AW-1:2]];
    if (w_commit && (w_sel_addr[AW-1:2] == r_addr[AW-1:2])) begin
      for (int b = 0; b < 4; b++) begin
        if (w_commit_be[b]) begin
          w_rd_word[8*b +: 8] = r_wdata[8*b +: 8];
        end else begin
          w_rd_word[8*b +: 8] = w_rd_word[8*b +: 8];
        end
      end
    end else begin
      w_rd_word = r_mem[w_sel_addr[AW-1:2]];
    end
  end

  always_comb begin
    w_resp_rdata = 32'h0000_0000;
    w_resp_err   = 1'b0;
    if (f_misaligned(w_sel_size, w_sel_addr[1:0])) begin
      w_resp_err = 1'b1;
    end else if (w_sel_wr) begin
      w_resp_err = 1'b0;
    end else begin
      w_resp_rdata = w_rd_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_data_ok <= 1'b0;
      r_rdata   <= 32'h0000_0000;
      r_err     <= 1'b0;
      r_wr      <= 1'b0;
      r_size    <= 2'd0;
      r_addr    <= '0;
      r_wdata   <= 32'h0000_0000;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_data_ok <= w_resp_next;
      if (w_accept) begin
        r_wr    <= bus.wr;
        r_size  <= bus.size;
        r_addr  <= bus.addr[AW-1:0];
        r_wdata <= bus.wdata;
      end
      if (w_resp_next) begin
        r_rdata <= w_resp_rdata;
        r_err   <= w_resp_err;
      end
    end
  end

  // Memory contents survive reset; only the committing response writes.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_commit_be[b]) begin
          r_mem[r_addr[AW-1:2]][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.addr_ok = w_addr_ok;
  assign bus.data_ok = r_data_ok;
  assign bus.rdata   = r_rdata;
  assign bus.err     = r_err;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench: LAT=1 instance under a randomized scoreboard, LAT=4 instance
// for held-request throughput and mid-transaction reset.
module tb_data_sram_responder;

  localparam int LAT_A = 1;
  localparam int LAT_B = 4;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  data_sram_if a_if ();
  data_sram_if b_if ();

  data_sram_responder #(.ADDR_LOG2(10), .LAT(LAT_A)) u_a (.clk(clk), .reset(rst_a), .bus(a_if.slave));
  data_sram_responder #(.ADDR_LOG2(10), .LAT(LAT_B)) u_b (.clk(clk), .reset(rst_b), .bus(b_if.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        qa[$];
  logic [31:0] mdl [0:1023];
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
  endtask

  // Reference: whole-word memory, lane replacement by byte count.
  task automatic model(input logic w, input logic [1:0] s, input logic [31:0] ad,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int idx, nb, lane;
    idx  = (ad / 4) % 1024;
    lane = ad % 4;
    rd   = 32'h0;
    er   = 1'b0;
    if (s == 2'd3) er = 1'b1;
    else if ((ad % (32'd1 << s)) != 0) er = 1'b1;
    if (!er) begin
      if (w) begin
        nb = 1 << s;
        for (int k = lane; k < lane + nb; k++) mdl[idx][8*k +: 8] = wd[8*k +: 8];
      end else begin
        rd = mdl[idx];
      end
    end
  endtask

  task automatic a_issue(input logic w, input logic [1:0] s, input logic [31:0] ad, input logic [31:0] wd);
    bit   acc;
    exp_t e;
    acc = 0;
    a_if.req = 1'b1; a_if.wr = w; a_if.size = s; a_if.addr = ad; a_if.wdata = wd;
    for (int g = 0; g < 40 && !acc; g++) begin
      @(negedge clk);
      if (a_if.addr_ok) begin
        acc = 1;
        model(w, s, ad, wd, e.rdata, e.err);
        e.due = cyc + LAT_A;
        qa.push_back(e);
      end
      @(posedge clk); #1;
    end
    a_if.req = 1'b0;
    chk("a_accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic a_drain();
    for (int g = 0; g < 50 && qa.size() != 0; g++) @(posedge clk);
    #1;
    chk("a_drain", 32'(qa.size()), 32'd0);
  endtask

  // Scoreboard monitor for the LAT=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (a_if.data_ok) begin
      chk("a_resp_pending", {31'b0, qa.size() > 0}, 32'd1);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_rdata", a_if.rdata, e.rdata);
        chk("a_err", {31'b0, a_if.err}, {31'b0, e.err});
        chk("a_latency", cyc, e.due);
        last_rdata = a_if.rdata;
        last_err   = a_if.err;
      end
    end
  end

  task automatic b_xact(input logic w, input logic [1:0] s, input logic [31:0] ad, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    bit acc, got;
    int t0;
    acc = 0; got = 0; lat = -1; rd = 32'hx; er = 1'bx; t0 = 0;
    b_if.req = 1'b1; b_if.wr = w; b_if.size = s; b_if.addr = ad; b_if.wdata = wd;
    for (int g = 0; g < 40 && !acc; g++) begin
      @(negedge clk);
      if (b_if.addr_ok) begin acc = 1; t0 = cyc; end
      @(posedge clk); #1;
    end
    b_if.req = 1'b0;
    for (int g = 0; g < 40 && acc && !got; g++) begin
      @(negedge clk);
      if (b_if.data_ok) begin got = 1; lat = cyc - t0; rd = b_if.rdata; er = b_if.err; end
      @(posedge clk); #1;
    end
    chk("b_response_seen", {31'b0, got}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd, ad;
    logic        er;
    int          lat;
    logic [12:0] ao_seen, do_seen;
    bit          any_dok;

    rst_a = 1'b1; rst_b = 1'b1;
    a_if.req = 1'b0; a_if.wr = 1'b0; a_if.size = 2'd0; a_if.addr = 32'h0; a_if.wdata = 32'h0;
    b_if.req = 1'b0; b_if.wr = 1'b0; b_if.size = 2'd0; b_if.addr = 32'h0; b_if.wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr_ok", {31'b0, a_if.addr_ok}, 32'd1);
    chk("rst_data_ok", {31'b0, a_if.data_ok}, 32'd0);
    chk("rst_rdata", a_if.rdata, 32'h0);
    chk("rst_err", {31'b0, a_if.err}, 32'd0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;

    for (int i = 0; i < 16; i++) a_issue(1'b1, 2'd2, 32'(i * 4), $urandom);

    a_issue(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
    a_issue(1'b0, 2'd2, 32'h10, 32'h0);
    a_drain();
    chk("word_store_load", last_rdata, 32'hDEADBEEF);

    a_issue(1'b1, 2'd0, 32'h11, 32'h0000AA00);
    a_issue(1'b1, 2'd1, 32'h12, 32'h55660000);
    a_issue(1'b0, 2'd2, 32'h10, 32'h0);
    a_drain();
    chk("byte_half_lanes", last_rdata, 32'h5566AAEF);

    a_issue(1'b0, 2'd2, 32'h12, 32'h0);
    a_drain();
    chk("misaligned_err", {31'b0, last_err}, 32'd1);
    chk("misaligned_rdata", last_rdata, 32'h0);
    a_issue(1'b1, 2'd1, 32'h13, 32'hFFFFFFFF);
    a_issue(1'b0, 2'd2, 32'h10, 32'h0);
    a_drain();
    chk("misaligned_no_write", last_rdata, 32'h5566AAEF);

    a_issue(1'b1, 2'd2, 32'h00001000, 32'h0BADCAFE);
    a_issue(1'b0, 2'd2, 32'h00000000, 32'h0);
    a_drain();
    chk("addr_wrap", last_rdata, 32'h0BADCAFE);

    for (int i = 0; i < 300; i++) begin
      ad = (($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_F000) : 32'h0)
           | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      a_issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ad, $urandom);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    a_drain();

    // LAT=4 with request held high for 13 cycles.
    b_if.req = 1'b1; b_if.wr = 1'b1; b_if.size = 2'd2; b_if.addr = 32'h20; b_if.wdata = 32'hCAFEF00D;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      ao_seen[k] = b_if.addr_ok;
      do_seen[k] = b_if.data_ok;
      @(posedge clk); #1;
    end
    b_if.req = 1'b0;
    chk("held_addr_ok_pattern", {19'b0, ao_seen}, 32'h1111);
    chk("held_data_ok_pattern", {19'b0, do_seen}, 32'h1110);
    repeat (6) @(posedge clk);
    #1;
    b_xact(1'b0, 2'd2, 32'h20, 32'h0, rd, er, lat);
    chk("b_load_value", rd, 32'hCAFEF00D);
    chk("b_load_latency", lat, LAT_B);

    // Store accepted at T, reset at T+2.
    b_if.req = 1'b1; b_if.wr = 1'b1; b_if.size = 2'd2; b_if.addr = 32'h20; b_if.wdata = 32'h12345678;
    any_dok = 0;
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      if (b_if.addr_ok) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    b_if.req = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b0;
    @(negedge clk);
    chk("post_reset_addr_ok", {31'b0, b_if.addr_ok}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      if (b_if.data_ok) any_dok = 1;
      @(negedge clk);
    end
    chk("reset_drops_response", {31'b0, any_dok}, 32'd0);
    @(posedge clk); #1;
    b_xact(1'b0, 2'd2, 32'h20, 32'h0, rd, er, lat);
    chk("reset_drops_write", rd, 32'hCAFEF00D);
    chk("b_err_clear", {31'b0, er}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
